// File: rtl/uart_line_tx_buf.sv
// Line-buffered 8N1 UART transmitter: queues 64-bit ASCII lines, sends non-NUL bytes first-byte-first plus optional '\n'.
// Push at T -> start bit at T+3; i_start is never stalled, a push into a full FIFO is dropped and flagged on o_drop.

// Generic single-clock FIFO; pushes into a full FIFO are ignored, pops of an empty FIFO are ignored.
module uart_line_fifo #(
  parameter int W      = 64,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] head_dat,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push_vld && (count != (AW+1)'(DEPTH));
  assign do_pop   = pop_rdy && (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module uart_line_tx_buf #(
  parameter int UART_TX_CLK_DIV = 434,
  parameter int LINE_FIFO_DEPTH = 4,
  parameter bit APPEND_NL       = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [63:0]                        i_data,
  output logic                               o_tx,
  output logic                               o_full,
  output logic [$clog2(LINE_FIFO_DEPTH):0]   o_level,
  output logic                               o_busy,
  output logic                               o_drop
);
  localparam int LW = $clog2(LINE_FIFO_DEPTH) + 1;
  localparam int TW = $clog2(UART_TX_CLK_DIV);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SEL   = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  logic [2:0]    state;
  logic [63:0]   line;
  logic [2:0]    idx;
  logic          done;
  logic          any_nz;
  logic          nl_frame;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic [TW-1:0] timer;
  logic          bit_end;
  logic [7:0]    cur_byte;
  logic [63:0]   head_dat;
  logic [LW-1:0] count;
  logic          fifo_empty;
  logic          push;

  assign fifo_empty = (count == '0);
  assign o_level    = count;
  assign o_full     = (count == LW'(LINE_FIFO_DEPTH));
  assign push       = i_start && !o_full;
  assign o_busy     = (state != IDLE) || !fifo_empty;
  assign bit_end    = (timer == TW'(UART_TX_CLK_DIV - 1));
  assign cur_byte   = line[{idx, 3'b000} +: 8];
  assign o_tx       = (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;

  uart_line_fifo #(.W(64), .DEPTH(LINE_FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push),
    .push_dat (i_data),
    .pop_rdy  (state == IDLE),
    .head_dat (head_dat),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      line     <= '0;
      idx      <= '0;
      done     <= 1'b0;
      any_nz   <= 1'b0;
      nl_frame <= 1'b0;
      shreg    <= '0;
      bit_idx  <= '0;
      timer    <= '0;
      o_drop   <= 1'b0;
    end else begin
      o_drop <= i_start && o_full;
      // Bit timer only runs while a frame is on the wire and restarts on every bit boundary.
      if ((state == START || state == DATA || state == STOP) && !bit_end)
        timer <= timer + 1'b1;
      else
        timer <= '0;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            line     <= head_dat;
            idx      <= 3'd7;
            done     <= 1'b0;
            any_nz   <= 1'b0;
            nl_frame <= 1'b0;
            // An all-NUL line produces no output at all, so it is discarded at pop.
            state    <= (head_dat == '0) ? IDLE : SEL;
          end
        end
        SEL: begin
          if (done) begin
            if (APPEND_NL && any_nz) begin
              shreg    <= 8'h0A;
              nl_frame <= 1'b1;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (cur_byte != 8'h00) begin
              shreg  <= cur_byte;
              any_nz <= 1'b1;
              state  <= START;
            end
            if (idx == 3'd0) done <= 1'b1;
            else             idx  <= idx - 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_idx == 3'd7) state   <= STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          // Without a terminator the last byte returns straight to IDLE.
          if (bit_end) state <= (nl_frame || (done && !APPEND_NL)) ? IDLE : SEL;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_line_tx_buf.sv
// Bench for uart_line_tx_buf: UART frame decoders on both DUTs, directed vector table, corner sequences and a randomized timeline model.
module tb_uart_line_tx_buf;
  localparam int DIV_A = 4;
  localparam int DIV_B = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic [7:0] b;
    int         st;
    bit         ok;
  } frame_t;

  typedef struct {
    logic [63:0] line;
    int          n;
    logic [71:0] exp;
    int          st[9];
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [63:0] data_a, data_b;
  logic        tx_a, full_a, busy_a, drop_a;
  logic        tx_b, full_b, busy_b, drop_b;
  logic [2:0]  level_a, level_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int drops_a = 0;

  frame_t rx_a[$];
  frame_t rx_b[$];
  frame_t exp_a[$];
  int     pop_q[$];
  int     d_free;
  int     exp_drops;

  uart_line_tx_buf #(.UART_TX_CLK_DIV(DIV_A), .LINE_FIFO_DEPTH(DEPTH), .APPEND_NL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .i_start(start_a), .i_data(data_a), .o_tx(tx_a),
    .o_full(full_a), .o_level(level_a), .o_busy(busy_a), .o_drop(drop_a));

  uart_line_tx_buf #(.UART_TX_CLK_DIV(DIV_B), .LINE_FIFO_DEPTH(DEPTH), .APPEND_NL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .i_start(start_b), .i_data(data_b), .o_tx(tx_b),
    .o_full(full_b), .o_level(level_b), .o_busy(busy_b), .o_drop(drop_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (drop_a) drops_a <= drops_a + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic txof(input int w);
    return (w == 0) ? tx_a : tx_b;
  endfunction

  // UART receiver: a frame is good only if every sample of each bit window agrees and the stop bit is high.
  task automatic monitor(input int which, input int div);
    logic [7:0] b;
    logic       v;
    bit         ok;
    int         st;
    forever begin
      @(posedge clk); #2;
      if (txof(which) === 1'b0) begin
        st = cyc;
        ok = 1'b1;
        for (int k = 1; k < div; k++) begin @(posedge clk); #2; if (txof(which) !== 1'b0) ok = 1'b0; end
        for (int bi = 0; bi < 8; bi++) begin
          @(posedge clk); #2;
          v = txof(which);
          b[bi] = v;
          for (int k = 1; k < div; k++) begin @(posedge clk); #2; if (txof(which) !== v) ok = 1'b0; end
        end
        for (int k = 0; k < div; k++) begin @(posedge clk); #2; if (txof(which) !== 1'b1) ok = 1'b0; end
        if (which == 0) rx_a.push_back('{b, st, ok});
        else            rx_b.push_back('{b, st, ok});
      end
    end
  endtask

  initial monitor(0, DIV_A);
  initial monitor(1, DIV_B);

  // Timeline model for DUT A: each line is popped at the first free cycle after its push,
  // then costs one cycle per examined byte slot plus 10*DIV per transmitted frame.
  function automatic void model_reset();
    pop_q.delete();
    exp_a.delete();
    d_free    = 0;
    exp_drops = 0;
  endfunction

  function automatic int model_level(input int t);
    int n = 0;
    foreach (pop_q[i]) if (pop_q[i] >= t) n++;
    return n;
  endfunction

  function automatic void model_push(input logic [63:0] line, input int t);
    int         p, sc;
    logic [7:0] b;
    if (model_level(t) == DEPTH) begin
      exp_drops++;
      return;
    end
    p = (t + 1 > d_free) ? t + 1 : d_free;
    pop_q.push_back(p);
    if (line == 64'h0) begin
      d_free = p + 1;
      return;
    end
    sc = p + 1;
    for (int i = 7; i >= 0; i--) begin
      b = line[i*8 +: 8];
      if (b == 8'h00) sc++;
      else begin
        exp_a.push_back('{b, sc + 1, 1'b1});
        sc = sc + 1 + 10 * DIV_A;
      end
    end
    exp_a.push_back('{8'h0A, sc + 1, 1'b1});
    d_free = sc + 1 + 10 * DIV_A;
  endfunction

  task automatic push_a(input logic [63:0] line, input bit use_model);
    if (use_model) model_push(line, cyc);
    start_a = 1'b1;
    data_a  = line;
    step();
    start_a = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int budget);
    int i = 0;
    while (((which == 0) ? busy_a : busy_b) && i < budget) begin
      step();
      i++;
    end
    if (i >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout dut%0d: still busy after %0d cycles, required idle", which, budget);
    end
    repeat (3) step();
  endtask

  task automatic cmp_rx_a(input string tag);
    frame_t f, e;
    int     k = 0;
    chk($sformatf("%s frame_count", tag), rx_a.size(), exp_a.size());
    while (rx_a.size() > 0 && exp_a.size() > 0) begin
      f = rx_a.pop_front();
      e = exp_a.pop_front();
      chk($sformatf("%s f%0d byte", tag, k), f.b, e.b);
      chk($sformatf("%s f%0d start", tag, k), f.st, e.st);
      chk($sformatf("%s f%0d framing", tag, k), f.ok, 1);
      k++;
    end
    rx_a.delete();
    exp_a.delete();
  endtask

  function automatic logic [63:0] rand_line();
    logic [63:0] l;
    for (int i = 0; i < 8; i++)
      l[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(33, 126));
    if ($urandom_range(0, 9) == 0) l = 64'h0;
    return l;
  endfunction

  initial begin
    vec_t        tbl[4];
    frame_t      f;
    logic [63:0] sb;
    int          t, base, cnt, maxl, gap;

    #20_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[4];
    frame_t      f;
    logic [63:0] sb;
    int          t, base, cnt, maxl, gap;

    tbl[0].line = "rst done"; tbl[0].n = 9; tbl[0].exp = 72'h72_73_74_20_64_6F_6E_65_0A;
    tbl[1].line = "wr done "; tbl[1].n = 9; tbl[1].exp = 72'h77_72_20_64_6F_6E_65_20_0A;
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < 9; k++) tbl[v].st[k] = 3 + 41 * k;
    tbl[2].line = 64'h31; tbl[2].n = 2; tbl[2].exp = 72'h31_0A_00_00_00_00_00_00_00;
    tbl[2].st = '{10, 51, 0, 0, 0, 0, 0, 0, 0};
    tbl[3].line = 64'h41_00_42_00_00_00_00_43; tbl[3].n = 4; tbl[3].exp = 72'h41_42_43_0A_00_00_00_00_00;
    tbl[3].st = '{3, 45, 90, 131, 0, 0, 0, 0, 0};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset tx_a", tx_a, 1);
    chk("reset full_a", full_a, 0);
    chk("reset level_a", level_a, 0);
    chk("reset busy_a", busy_a, 0);
    chk("reset drop_a", drop_a, 0);
    chk("reset tx_b", tx_b, 1);
    chk("reset busy_b", busy_b, 0);

    for (int v = 0; v < 4; v++) begin
      t = cyc;
      push_a(tbl[v].line, 1'b0);
      wait_idle(0, 800);
      chk($sformatf("tbl%0d frame_count", v), rx_a.size(), tbl[v].n);
      for (int k = 0; k < tbl[v].n && rx_a.size() > 0; k++) begin
        f = rx_a.pop_front();
        chk($sformatf("tbl%0d f%0d byte", v, k), f.b, tbl[v].exp[71 - 8*k -: 8]);
        chk($sformatf("tbl%0d f%0d start", v, k), f.st - t, tbl[v].st[k]);
        chk($sformatf("tbl%0d f%0d framing", v, k), f.ok, 1);
      end
      rx_a.delete();
    end

    // All-NUL line: nothing on the wire, busy only briefly.
    push_a(64'h0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy_a) cnt++;
      chk("nul_line tx", tx_a, 1);
      step();
    end
    chk("nul_line busy_short", cnt <= 3, 1);
    chk("nul_line no_frames", rx_a.size(), 0);

    // Two replies in consecutive cycles.
    model_reset();
    base = drops_a;
    t = cyc;
    push_a("wr done ", 1'b1);
    push_a("stoped  ", 1'b1);
    maxl = 0;
    for (int i = 0; i < 10; i++) begin
      if (int'(level_a) > maxl) maxl = level_a;
      step();
    end
    chk("pair level_peak", maxl, 1);
    wait_idle(0, 1500);
    cmp_rx_a("pair");
    chk("pair drops", drops_a - base, 0);

    // Six back-to-back lines into a 4-deep FIFO.
    model_reset();
    base = drops_a;
    for (int i = 0; i < 6; i++) push_a({"line #", 8'(8'h30 + i), " "}, 1'b1);
    chk("burst full", full_a, 1);
    chk("burst level", level_a, 4);
    chk("burst drop_pulse", drop_a, 1);
    step();
    chk("burst drop_clear", drop_a, 0);
    wait_idle(0, 3000);
    cmp_rx_a("burst");
    chk("burst drops", drops_a - base, 1);

    // Reset while bit 3 of the second byte is on the wire.
    t = cyc;
    push_a("rst done", 1'b0);
    push_a("wr done ", 1'b0);
    while (cyc < t + 61) step();
    chk("midreset pre tx_bit3", tx_a, 0);
    chk("midreset pre level", level_a, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset tx", tx_a, 1);
    chk("midreset level", level_a, 0);
    chk("midreset busy", busy_a, 0);
    repeat (60) step();
    rx_a.delete();
    model_reset();
    push_a("wr done ", 1'b1);
    wait_idle(0, 800);
    cmp_rx_a("post_reset");

    // No terminator, DIV=2.
    sb = "00000100";
    t = cyc;
    start_b = 1'b1; data_b = sb;
    step();
    start_b = 1'b0;
    while (cyc < t + 169) step();
    chk("nonl busy_last_stop", busy_b, 1);
    step();
    chk("nonl busy_drop", busy_b, 0);
    repeat (3) step();
    chk("nonl frame_count", rx_b.size(), 8);
    for (int k = 0; k < 8 && rx_b.size() > 0; k++) begin
      f = rx_b.pop_front();
      chk($sformatf("nonl f%0d byte", k), f.b, sb[63 - 8*k -: 8]);
      chk($sformatf("nonl f%0d start", k), f.st - t, 3 + 21 * k);
      chk($sformatf("nonl f%0d framing", k), f.ok, 1);
    end
    rx_b.delete();

    // Randomized lines and gaps against the timeline model.
    model_reset();
    base = drops_a;
    for (int i = 0; i < 25; i++) begin
      chk($sformatf("rnd%0d level", i), level_a, model_level(cyc));
      chk($sformatf("rnd%0d full", i), full_a, model_level(cyc) == DEPTH);
      push_a(rand_line(), 1'b1);
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 300);
      repeat (gap) step();
    end
    while (cyc < d_free + 3) step();
    chk("rnd busy_end", busy_a, 0);
    cmp_rx_a("rnd");
    chk("rnd drops", drops_a - base, exp_drops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
